// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, default playfield size and lives width.
package game_pkg;

    localparam int c_DEF_GAME_WIDTH  = 640;
    localparam int c_DEF_GAME_HEIGHT = 480;
    localparam int c_LIVES_W         = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_GRACE = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

endpackage

// File: rtl/collision_ctrl_if.sv
// Pixel-stream inputs and game-status outputs of the collision controller.
interface collision_ctrl_if
    import game_pkg::*;
#(
    parameter int c_NUM_CARS = 4
);
    logic                  i_Start;
    logic [9:0]            i_Col_Count_Div;
    logic [9:0]            i_Row_Count_Div;
    logic                  i_Draw_Frog;
    logic [c_NUM_CARS-1:0] i_Draw_Cars;
    logic                  i_Frog_Goal;
    logic                  o_Game_Active;
    logic                  o_Hit;
    logic [c_LIVES_W-1:0]  o_Lives;
    logic [2:0]            o_State;
    logic                  o_Draw_Hit;

    modport slave (
        input  i_Start, i_Col_Count_Div, i_Row_Count_Div, i_Draw_Frog, i_Draw_Cars, i_Frog_Goal,
        output o_Game_Active, o_Hit, o_Lives, o_State, o_Draw_Hit
    );

    modport master (
        output i_Start, i_Col_Count_Div, i_Row_Count_Div, i_Draw_Frog, i_Draw_Cars, i_Frog_Goal,
        input  o_Game_Active, o_Hit, o_Lives, o_State, o_Draw_Hit
    );
endinterface

// File: rtl/frame_tick_gen.sv
// Delays the pixel counters one cycle to line up with registered draw bits, and
// flags the active area and the last active pixel of each frame.
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int c_GAME_WIDTH  = c_DEF_GAME_WIDTH,
    parameter int c_GAME_HEIGHT = c_DEF_GAME_HEIGHT
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [9:0] i_Col,
    input  logic [9:0] i_Row,
    output logic [9:0] o_Col_Dly,
    output logic [9:0] o_Row_Dly,
    output logic       o_Active,
    output logic       o_Frame_Tick
);
    logic [9:0] col_q;
    logic [9:0] row_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= i_Col;
            row_q <= i_Row;
        end
    end

    assign o_Col_Dly    = col_q;
    assign o_Row_Dly    = row_q;
    assign o_Active     = (col_q < 10'(c_GAME_WIDTH)) && (row_q < 10'(c_GAME_HEIGHT));
    assign o_Frame_Tick = (col_q == 10'(c_GAME_WIDTH - 1)) && (row_q == 10'(c_GAME_HEIGHT - 1));
endmodule

// File: rtl/collision_ctrl.sv
// Frog/car overlap counting and game FSM (lives, grace, over, win).
// Define HIT_FLASH_EN to blink the frog via o_Draw_Hit during the grace period.
module collision_ctrl
    import game_pkg::*;
#(
    parameter int c_NUM_CARS      = 4,
    parameter int c_GAME_WIDTH    = c_DEF_GAME_WIDTH,
    parameter int c_GAME_HEIGHT   = c_DEF_GAME_HEIGHT,
    parameter int c_LIVES         = 3,
    parameter int c_HIT_THRESHOLD = 4,
    parameter int c_GRACE_FRAMES  = 60
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    collision_ctrl_if.slave  bus
);
    logic [9:0]            col_dly_unused;
    logic [9:0]            row_dly_unused;
    logic                  active;
    logic                  frame_tick;
    logic [c_NUM_CARS-1:0] cars;
    logic                  overlap;
    logic [7:0]            ovl_cnt_q, ovl_cnt_d;
    logic [8:0]            ovl_eval;
    logic                  hit_now;

    state_t                state_q;
    logic [c_LIVES_W-1:0]  lives_q;
    logic [7:0]            grace_q;
    logic                  game_active_q;
    logic                  hit_q;

    frame_tick_gen #(
        .c_GAME_WIDTH  (c_GAME_WIDTH),
        .c_GAME_HEIGHT (c_GAME_HEIGHT)
    ) u_tick (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Col        (bus.i_Col_Count_Div),
        .i_Row        (bus.i_Row_Count_Div),
        .o_Col_Dly    (col_dly_unused),
        .o_Row_Dly    (row_dly_unused),
        .o_Active     (active),
        .o_Frame_Tick (frame_tick)
    );

    assign cars    = bus.i_Draw_Cars;
    assign overlap = bus.i_Draw_Frog & (|cars) & active;

    // The final pixel's overlap lands in the tick cycle, so fold it into the evaluation.
    assign ovl_eval = {1'b0, ovl_cnt_q} + {8'd0, overlap};
    assign hit_now  = (state_q == S_PLAY) && frame_tick && (ovl_eval >= 9'(c_HIT_THRESHOLD));

    always_comb begin
        ovl_cnt_d = ovl_cnt_q;
        if (frame_tick || (state_q != S_PLAY)) begin
            ovl_cnt_d = '0;
        end else if (overlap && (ovl_cnt_q < 8'(c_HIT_THRESHOLD))) begin
            ovl_cnt_d = ovl_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) ovl_cnt_q <= '0;
        else          ovl_cnt_q <= ovl_cnt_d;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q       <= S_IDLE;
            lives_q       <= c_LIVES_W'(c_LIVES);
            grace_q       <= '0;
            game_active_q <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER, S_WIN: begin
                    if (bus.i_Start) begin
                        state_q       <= S_PLAY;
                        lives_q       <= c_LIVES_W'(c_LIVES);
                        game_active_q <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (hit_now) begin
                        hit_q   <= 1'b1;
                        lives_q <= (lives_q != '0) ? lives_q - 1'b1 : lives_q;
                        if (lives_q <= c_LIVES_W'(1)) begin
                            state_q       <= S_OVER;
                            game_active_q <= 1'b0;
                        end else begin
                            state_q <= S_GRACE;
                            grace_q <= '0;
                        end
                    end else if (frame_tick && bus.i_Frog_Goal) begin
                        state_q       <= S_WIN;
                        game_active_q <= 1'b0;
                    end
                end
                S_GRACE: begin
                    if (frame_tick) begin
                        if (grace_q == 8'(c_GRACE_FRAMES - 1)) state_q <= S_PLAY;
                        else                                   grace_q <= grace_q + 8'd1;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    game_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_State       = state_q;
    assign bus.o_Lives       = lives_q;
    assign bus.o_Hit         = hit_q;
    assign bus.o_Game_Active = game_active_q;

`ifdef HIT_FLASH_EN
    logic draw_hit_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) draw_hit_q <= 1'b0;
        else          draw_hit_q <= (state_q == S_GRACE) & grace_q[3];
    end

    assign bus.o_Draw_Hit = draw_hit_q;
`else
    assign bus.o_Draw_Hit = 1'b0;
`endif
endmodule

// File: tb/tb_collision_ctrl.sv
// Scoreboard bench for collision_ctrl: stimulus queues expected status events, a monitor checks them.
module tb_collision_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    collision_ctrl_if #(.c_NUM_CARS(4)) bus ();

    collision_ctrl #(.c_NUM_CARS(4)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic       hit;
        logic [2:0] st;
        logic [2:0] lives;
        logic       act;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic       pend_f;
    logic [3:0] pend_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic push(input int c, input logic h, input logic [2:0] s, input logic [2:0] l, input logic a);
        exp_t e;
        e.cyc = c; e.hit = h; e.st = s; e.lives = l; e.act = a;
        sb.push_back(e);
    endtask

    // Coordinates go out now; draw bits for a pixel follow one cycle later.
    task automatic drive_px(input int c, input int r, input logic f, input logic [3:0] cars);
        @(negedge clk);
        bus.i_Col_Count_Div = 10'(c);
        bus.i_Row_Count_Div = 10'(r);
        bus.i_Draw_Frog     = pend_f;
        bus.i_Draw_Cars     = pend_c;
        pend_f = f;
        pend_c = cars;
    endtask

    task automatic frame(input int n_ovl, input bit last_ovl, input bit goal, input bit noise,
                         input bit exp_v, input logic h, input logic [2:0] s,
                         input logic [2:0] l, input logic a);
        bus.i_Frog_Goal = goal;
        for (int i = 0; i < n_ovl; i++) drive_px(20 + 3 * i, 50 + i, 1'b1, 4'(1 << (i % 4)));
        if (noise) begin
            drive_px(300, 60, 1'b1, 4'h0);
            drive_px(301, 60, 1'b0, 4'hF);
            drive_px(640, 100, 1'b1, 4'hF);
            drive_px(100, 480, 1'b1, 4'h1);
            drive_px(639, 480, 1'b1, 4'h8);
            drive_px(1023, 1023, 1'b1, 4'h2);
        end
        drive_px(638, 479, 1'b0, 4'h0);
        drive_px(639, 479, last_ovl, last_ovl ? 4'h4 : 4'h0);
        if (exp_v) push(cyc + 2, h, s, l, a);
        drive_px(0, 0, 1'b0, 4'h0);
        drive_px(0, 0, 1'b0, 4'h0);
        bus.i_Frog_Goal = 1'b0;
    endtask

    task automatic start(input bit exp_v, input logic h, input logic [2:0] s,
                         input logic [2:0] l, input logic a);
        @(negedge clk);
        bus.i_Start = 1'b1;
        if (exp_v) push(cyc + 1, h, s, l, a);
        @(negedge clk);
        bus.i_Start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        push(cyc + 1, 1'b0, S_IDLE, 3'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        logic [2:0] ps, pl;
        bit         init;
        exp_t       e;
        init = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) continue;
            if (!init) begin
                ps = bus.o_State; pl = bus.o_Lives; init = 1'b1;
                continue;
            end
            if (bus.o_Hit || (bus.o_State != ps) || (bus.o_Lives != pl)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got state %0d lives %0d hit %0b at cycle %0d, expected no change",
                             bus.o_State, bus.o_Lives, bus.o_Hit, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("hit", bus.o_Hit, e.hit);
                    chk("state", bus.o_State, e.st);
                    chk("lives", bus.o_Lives, e.lives);
                    chk("game_active", bus.o_Game_Active, e.act);
`ifndef HIT_FLASH_EN
                    chk("draw_hit", bus.o_Draw_Hit, 0);
`endif
                end
            end
            ps = bus.o_State;
            pl = bus.o_Lives;
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        bus.i_Start = 1'b0;
        bus.i_Col_Count_Div = '0;
        bus.i_Row_Count_Div = '0;
        bus.i_Draw_Frog = 1'b0;
        bus.i_Draw_Cars = '0;
        bus.i_Frog_Goal = 1'b0;
        pend_f = 1'b0;
        pend_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_state", bus.o_State, S_IDLE);
        chk("rst_active", bus.o_Game_Active, 0);
        chk("rst_lives", bus.o_Lives, 3);
        chk("rst_hit", bus.o_Hit, 0);
        mon_en = 1'b1;

        // Overlap and goal while idle change nothing
        frame(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, S_IDLE, 3'd3, 1'b0);

        start(1'b1, 1'b0, S_PLAY, 3'd3, 1'b1);
        frame(4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_GRACE, 3'd2, 1'b1);

        // Grace: full overlap ignored, back to PLAY on the 60th tick
        for (int f = 1; f <= 60; f++)
            frame(5, 1'b1, 1'b0, 1'b0, f == 60, 1'b0, S_PLAY, 3'd2, 1'b1);

        // Three in-area overlaps plus off-area overlaps: below threshold
        frame(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_PLAY, 3'd2, 1'b1);
        // Fourth overlap on the very last pixel completes the hit
        frame(3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S_GRACE, 3'd1, 1'b1);

        for (int f = 1; f <= 60; f++)
            frame(0, 1'b0, 1'b0, 1'b0, f == 60, 1'b0, S_PLAY, 3'd1, 1'b1);
        frame(4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_OVER, 3'd0, 1'b0);
        frame(6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_OVER, 3'd0, 1'b0);
        start(1'b1, 1'b0, S_PLAY, 3'd3, 1'b1);

        // Hit and goal together: hit wins
        frame(4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_GRACE, 3'd2, 1'b1);
        start(1'b0, 1'b0, S_GRACE, 3'd2, 1'b1);
        for (int f = 1; f <= 60; f++)
            frame(0, 1'b0, 1'b1, 1'b0, f == 60, 1'b0, S_PLAY, 3'd2, 1'b1);
        start(1'b0, 1'b0, S_PLAY, 3'd2, 1'b1);
        frame(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, S_WIN, 3'd2, 1'b0);
        frame(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_WIN, 3'd2, 1'b0);
        reset_pulse();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Sits directly downstream of the car controllers and the frog controller.
- Consumes every car's registered draw bit and the frog's draw bit on the same pixel stream, and counts frog/car pixel overlap per frame.
- Runs the game state machine: lives, post-hit grace period, game over and win.
- Drives o_Game_Active, which feeds i_Game_Active of every car controller; deasserting it parks all cars at their initial positions.

Parameters:
c_NUM_CARS, 4, number of car draw inputs
c_GAME_WIDTH, 640, active columns
c_GAME_HEIGHT, 480, active rows
c_LIVES, 3, lives loaded on game start (1..7)
c_HIT_THRESHOLD, 4, minimum overlapping pixels in one frame that count as a hit (1..255)
c_GRACE_FRAMES, 60, frames of collision immunity after a hit (1..255)

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  synchronous reset, active-low
i_Start  in  1  one-cycle start pulse (debounced button)
i_Col_Count_Div  in  10  current column, same counters that feed the car controllers
i_Row_Count_Div  in  10  current row
i_Draw_Frog  in  1  frog draw bit, registered one cycle after counters
i_Draw_Cars  in  c_NUM_CARS  car draw bits, registered one cycle after counters
i_Frog_Goal  in  1  level-high while frog occupies goal row
o_Game_Active  out  1  high in PLAY and GRACE
o_Hit  out  1  one-cycle pulse on a registered hit
o_Lives  out  3  remaining lives
o_State  out  3  current state encoding, for HUD/debug
o_Draw_Hit  out  1  frog flash-blank overlay (see Optional Feature)

Behaviour:
- Clock and reset:
  - Single clock i_Clk; reset is synchronous, active-low, on i_Rst_n.
  - Reset values: state IDLE, o_Lives=c_LIVES, o_Game_Active=0, o_Hit=0, o_Draw_Hit=0, overlap and grace counters 0.
  - Reset asserted mid-game forces IDLE on the next edge, whatever the current state.
- Pixel alignment:
  - Column and row counters are delayed one cycle internally so they line up with the registered draw bits.
  - All comparisons below use the delayed coordinates.
- Overlap detection:
  - Overlap is asserted when i_Draw_Frog & (|i_Draw_Cars) and the delayed coordinate lies inside the active area.
  - The overlap counter is 8 bits, increments on each overlap, and saturates at c_HIT_THRESHOLD.
- Frame tick:
  - Asserted for one cycle when delayed col == c_GAME_WIDTH-1 and delayed row == c_GAME_HEIGHT-1.
  - The overlap of that final pixel is included in the evaluation.
  - The overlap counter clears on the cycle after the tick.
- FSM states: IDLE, PLAY, GRACE, OVER, WIN.
  - IDLE: o_Game_Active=0. i_Start moves to PLAY and reloads o_Lives=c_LIVES.
  - PLAY: o_Game_Active=1. At the frame tick:
    - overlap >= c_HIT_THRESHOLD counts as a hit: o_Hit pulses on the next cycle and o_Lives decrements.
    - If o_Lives was 1, go to OVER; otherwise go to GRACE with the grace counter set to 0.
    - With no hit and i_Frog_Goal=1, go to WIN.
    - Hit and goal in the same frame: the hit wins.
    - i_Frog_Goal is sampled only at the frame tick.
  - GRACE: o_Game_Active=1; overlap is ignored (counter held at 0). The grace counter increments per frame tick. When it reaches c_GRACE_FRAMES-1 at a tick, go to PLAY.
  - OVER and WIN: o_Game_Active=0 and o_Lives holds its value. i_Start moves to PLAY with lives reloaded.
  - i_Start has no effect in PLAY or GRACE.
- o_Hit latency is exactly 1 cycle after the frame-tick cycle. Only one hit is possible per frame.
- o_Lives never underflows.
- o_State encoding: IDLE=0, PLAY=1, GRACE=2, OVER=3, WIN=4.

Optional Feature:
HIT_FLASH_EN
- Defined: in GRACE, o_Draw_Hit = grace_counter[3], registered, so the frog blinks every 8 frames. o_Draw_Hit=0 in all other states.
- Undefined: o_Draw_Hit is tied to 0 and no extra logic is generated.

Decomposition:
- Shared package game_pkg holds:
  - state encoding constants S_IDLE..S_WIN;
  - c_GAME_WIDTH and c_GAME_HEIGHT defaults;
  - lives width (3).
- One sub-module, frame_tick_gen. Inputs: clock, reset, col/row. Outputs: delayed col/row, active flag and one-cycle frame tick. It is reusable by the frog and score blocks.

Test Plan:
1. Reset low for 2 cycles, then high with no i_Start: o_State=0, o_Game_Active=0, o_Lives=3, o_Hit never pulses.
2. i_Start, then frog and car bits overlapping on 4 pixels in frame 1: o_Hit pulses 1 cycle after the tick at (639,479); o_Lives=2; o_State=2.
3. Only 3 overlapping pixels in a PLAY frame: no o_Hit, lives unchanged. Overlap on last pixel (639,479) making 4: hit registered.
4. In GRACE, full overlap every frame for 60 frames: no o_Hit; state returns to 1 after the 60th tick. Then 1 overlap frame: hit, o_Lives=1.
5. Three hits separated by grace periods: o_State=3, o_Game_Active=0, o_Lives=0. i_Start: o_Lives=3, o_State=1.
6. i_Frog_Goal=1 and hit in the same frame: hit taken, no WIN. Goal alone: o_State=4. Reset pulse in WIN: o_State=0 next edge.
